// File: rtl/jpeg_lift_pkg.sv
// Shared FSM encoding, pass constants and boundary mirroring for the 5/3 lifting row sequencer.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package jpeg_lift_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_L  = 3'd1;
    localparam logic [2:0] ST_RD_S  = 3'd2;
    localparam logic [2:0] ST_RD_R  = 3'd3;
    localparam logic [2:0] ST_CAP_R = 3'd4;
    localparam logic [2:0] ST_LIFT  = 3'd5;
    localparam logic [2:0] ST_WR    = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // Value driven on lift_e_o: predict works on odd targets, update on even ones.
    localparam logic PASS_PRED = 1'b0;
    localparam logic PASS_UPD  = 1'b1;

    // Whole-sample symmetric extension: -1 folds to 1, len folds to len-2.
    function automatic int mirror_idx(input int idx, input int len);
        if (idx < 0) begin
            return -idx;
        end
        if (idx >= len) begin
            return 2 * len - 2 - idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/jpeg_lift_addr.sv
// Maps a target sample index to RAM addresses of its left, centre and right operands.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module jpeg_lift_addr
    import jpeg_lift_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [AW:0]   tgt,
    output logic [AW-1:0] addr_l,
    output logic [AW-1:0] addr_s,
    output logic [AW-1:0] addr_r
);

    int idx_l;
    int idx_r;

    // Mirror neighbour indices at the row ends, then offset by base; the AW-bit add wraps the RAM.
    always_comb begin
        idx_l  = mirror_idx(int'(tgt) - 1, int'(len));
        idx_r  = mirror_idx(int'(tgt) + 1, int'(len));
        addr_l = base + AW'(idx_l);
        addr_s = base + AW'(tgt);
        addr_r = base + AW'(idx_r);
    end

endmodule

// File: rtl/jpeg_lift_ctrl.sv
// Sequences predict and update lifting passes over one row in RAM, writing each result in place.
// Latency: 5+LIFT_LAT cycles per target (4+LIFT_LAT with JPEG_LIFT_WINDOW_EN after a pass's first target), plus one done cycle.
// Backpressure: none; start is ignored while busy, lift_res is sampled LIFT_LAT cycles after operands settle.
module jpeg_lift_ctrl
    import jpeg_lift_pkg::*;
#(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int LIFT_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW:0]   cfg_len,
    input  logic          cfg_fwd,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_dv,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [DW-1:0] lift_l,
    output logic [DW-1:0] lift_r,
    output logic [DW-1:0] lift_s,
    output logic          lift_e_o,
    output logic          lift_f_i,
    input  logic [DW-1:0] lift_res
);

    localparam int          LCW      = (LIFT_LAT > 1) ? $clog2(LIFT_LAT) : 1;
    localparam logic [LCW-1:0] LAT_LAST = LCW'(LIFT_LAT - 1);
    localparam logic [AW:0] LEN_MAX  = {1'b1, {AW{1'b0}}};

    logic [2:0]     state;
    logic [AW-1:0]  base_q;
    logic [AW:0]    len_q;
    logic [AW:0]    tgt;
    logic [AW:0]    tgt_nxt;
    logic           second;
    logic           skip_l;
    logic [LCW-1:0] lat_cnt;
    logic           len_bad;
    logic [AW-1:0]  addr_l;
    logic [AW-1:0]  addr_s;
    logic [AW-1:0]  addr_r;

    jpeg_lift_addr #(
        .AW (AW)
    ) u_addr (
        .base   (base_q),
        .len    (len_q),
        .tgt    (tgt),
        .addr_l (addr_l),
        .addr_s (addr_s),
        .addr_r (addr_r)
    );

    assign tgt_nxt = tgt + (AW+1)'(2);

    // Row must be even, at least one pair, and fit in the RAM.
    assign len_bad = cfg_len[0] || (cfg_len < (AW+1)'(2)) || (cfg_len > LEN_MAX);

    // RAM and status strobes decode from state only, so reset clears them immediately.
    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE);
        rd_en   = (state == ST_RD_L) || (state == ST_RD_S) || (state == ST_RD_R);
        wr_dv   = (state == ST_WR);
        rd_addr = '0;
        case (state)
            ST_RD_L: rd_addr = addr_l;
            ST_RD_S: rd_addr = addr_s;
            ST_RD_R: rd_addr = addr_r;
            default: rd_addr = '0;
        endcase
        wr_addr = wr_dv ? addr_s   : '0;
        wr_data = wr_dv ? lift_res : '0;
    end

    // Row sequencer: latch config, fetch three operands, wait on the lifting unit, write back, advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            tgt      <= '0;
            second   <= 1'b0;
            skip_l   <= 1'b0;
            lat_cnt  <= '0;
            err      <= 1'b0;
            lift_l   <= '0;
            lift_r   <= '0;
            lift_s   <= '0;
            lift_e_o <= 1'b0;
            lift_f_i <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_bad) begin
                            err <= 1'b1;
                        end else begin
                            base_q   <= cfg_base;
                            len_q    <= cfg_len;
                            lift_f_i <= cfg_fwd;
                            lift_e_o <= cfg_fwd ? PASS_PRED : PASS_UPD;
                            tgt      <= cfg_fwd ? (AW+1)'(1) : (AW+1)'(0);
                            second   <= 1'b0;
                            skip_l   <= 1'b0;
                            state    <= ST_RD_L;
                        end
                    end
                end
                ST_RD_L: begin
                    state <= ST_RD_S;
                end
                ST_RD_S: begin
                    // With skip_l set, the previous target's right operand is this target's left.
                    lift_l <= skip_l ? lift_r : rd_data;
                    state  <= ST_RD_R;
                end
                ST_RD_R: begin
                    lift_s <= rd_data;
                    state  <= ST_CAP_R;
                end
                ST_CAP_R: begin
                    lift_r  <= rd_data;
                    lat_cnt <= '0;
                    state   <= ST_LIFT;
                end
                ST_LIFT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= ST_WR;
                    end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                    end
                end
                ST_WR: begin
                    if (tgt_nxt < len_q) begin
                        tgt <= tgt_nxt;
`ifdef JPEG_LIFT_WINDOW_EN
                        skip_l <= 1'b1;
                        state  <= ST_RD_S;
`else
                        skip_l <= 1'b0;
                        state  <= ST_RD_L;
`endif
                    end else if (!second) begin
                        second   <= 1'b1;
                        skip_l   <= 1'b0;
                        lift_e_o <= ~lift_e_o;
                        tgt      <= (lift_e_o == PASS_UPD) ? (AW+1)'(1) : (AW+1)'(0);
                        state    <= ST_RD_L;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_lift_ctrl.sv
// Bench for jpeg_lift_ctrl: behavioural row RAM and 5/3 lifting unit around the sequencer.
// Latency: lifting model has one registered stage (LIFT_LAT=1).
// Backpressure: none; directed rows with hand-computed results.
module tb_jpeg_lift_ctrl;

`ifdef JPEG_LIFT_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  cfg_base;
    logic [6:0]  cfg_len;
    logic        cfg_fwd;
    logic        busy, done, err, rd_en, wr_dv;
    logic [5:0]  rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic [15:0] lift_l, lift_r, lift_s, lift_res;
    logic        lift_e_o, lift_f_i;

    logic [15:0] mem [0:63];
    logic        tb_we;
    logic [5:0]  tb_wa;
    logic [15:0] tb_wd;
    logic        tb_clr;
    int          rd_log [0:255];
    int          wr_log [0:255];
    int          rd_n, wr_n, overlap;

    int n_chk = 0;
    int n_err = 0;

    jpeg_lift_ctrl #(.AW(6), .DW(16), .LIFT_LAT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .cfg_fwd  (cfg_fwd),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_dv    (wr_dv),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lift_l   (lift_l),
        .lift_r   (lift_r),
        .lift_s   (lift_s),
        .lift_e_o (lift_e_o),
        .lift_f_i (lift_f_i),
        .lift_res (lift_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Row RAM with one-cycle read, plus access logging and a bench-side load port.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_dv) mem[wr_addr] <= wr_data;
        else if (tb_we) mem[tb_wa] <= tb_wd;
        if (tb_clr) begin
            rd_n    <= 0;
            wr_n    <= 0;
            overlap <= 0;
        end else begin
            if (rd_en && rd_n < 256) begin
                rd_log[rd_n] <= int'(rd_addr);
                rd_n         <= rd_n + 1;
            end
            if (wr_dv && wr_n < 256) begin
                wr_log[wr_n] <= int'(wr_addr);
                wr_n         <= wr_n + 1;
            end
            if (rd_en && wr_dv) overlap <= overlap + 1;
        end
    end

    // Le Gall 5/3 lifting unit, one register stage.
    logic signed [31:0] lsum, pterm, uterm;
    assign lsum  = 32'($signed(lift_l)) + 32'($signed(lift_r));
    assign pterm = lsum >>> 1;
    assign uterm = (lsum + 32'sd2) >>> 2;
    always @(posedge clk) begin
        if (!lift_e_o) lift_res <= lift_f_i ? 16'(32'($signed(lift_s)) - pterm) : 16'(32'($signed(lift_s)) + pterm);
        else           lift_res <= lift_f_i ? 16'(32'($signed(lift_s)) + uterm) : 16'(32'($signed(lift_s)) - uterm);
    end

    logic [12:0] outs;
    assign outs = {busy, done, err, rd_en, wr_dv, |rd_addr, |wr_addr, |wr_data,
                   |lift_l, |lift_r, |lift_s, lift_e_o, lift_f_i};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_busy(input int len);
        return WIN ? len * 5 + 3 : len * 6 + 1;
    endfunction

    function automatic int exp_reads(input int len);
        return WIN ? 2 * len + 2 : 3 * len;
    endfunction

    task automatic load(input logic [5:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic clear_logs();
        tb_clr = 1'b1;
        @(posedge clk); #1;
        tb_clr = 1'b0;
    endtask

    // Start one row and follow it until busy drops; poke_at injects a stray start, stop_at asserts reset.
    task automatic run_row(input logic [5:0] base, input logic [6:0] len, input logic fwd,
                           input int poke_at, input int stop_at,
                           output int busy_len, output int done_at);
        clear_logs();
        cfg_base = base; cfg_len = len; cfg_fwd = fwd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_len = 0;
        done_at  = 0;
        for (int c = 1; c <= 1000; c++) begin
            if (c == poke_at) begin
                cfg_base = 6'd0; cfg_len = 7'd8; cfg_fwd = ~fwd; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == stop_at) begin
                rst_n = 1'b0;
                break;
            end
            if (!busy) break;
            busy_len++;
            if (done) done_at = c;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic err_case(input logic [6:0] len);
        clear_logs();
        cfg_base = 6'd3; cfg_len = len; cfg_fwd = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq($sformatf("err_pulse_len%0d", len), err, 1);
        check_eq($sformatf("err_busy_len%0d", len), busy, 0);
        @(posedge clk); #1;
        check_eq($sformatf("err_clear_len%0d", len), {err, busy}, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq($sformatf("err_noaccess_len%0d", len), rd_n + wr_n, 0);
    endtask

    int bl, da, bad;
    logic [15:0] row8_fwd [0:7];

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_fwd = 1'b0;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0; tb_clr = 1'b1;
        row8_fwd = '{16'd55, 16'd0, 16'd57, 16'd0, 16'd59, 16'd0, 16'd61, 16'd1};
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", outs, 0);
        rst_n = 1'b1; tb_clr = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_busy", busy, 0);

        // Two-sample row: one predict target, one update target.
        load(6'd0, 16'd10); load(6'd1, 16'd20);
        run_row(6'd0, 7'd2, 1'b1, 0, 0, bl, da);
        check_eq("len2_busy", bl, 13);
        check_eq("len2_done_at", da, 13);
        check_eq("len2_reads", rd_n, 6);
        check_eq("len2_rd0", rd_log[0], 0);
        check_eq("len2_rd1", rd_log[1], 1);
        check_eq("len2_rd2", rd_log[2], 0);
        check_eq("len2_rd3", rd_log[3], 1);
        check_eq("len2_rd4", rd_log[4], 0);
        check_eq("len2_rd5", rd_log[5], 1);
        check_eq("len2_writes", wr_n, 2);
        check_eq("len2_wr0", wr_log[0], 1);
        check_eq("len2_wr1", wr_log[1], 0);
        check_eq("len2_mem0", mem[0], 15);
        check_eq("len2_mem1", mem[1], 10);

        // Eight-sample ramp forward, then inverse back to the ramp.
        for (int i = 0; i < 8; i++) load(6'(i), 16'(55 + i));
        load(6'd8, 16'd999);
        run_row(6'd0, 7'd8, 1'b1, 0, 0, bl, da);
        check_eq("len8_busy", bl, exp_busy(8));
        check_eq("len8_done_at", da, exp_busy(8));
        check_eq("len8_reads", rd_n, exp_reads(8));
        check_eq("len8_t7_r_addr", rd_log[WIN ? 8 : 11], 6);
        check_eq("len8_overlap", overlap, 0);
        bad = 0;
        for (int i = 0; i < rd_n; i++) if (rd_log[i] > 7) bad++;
        check_eq("len8_rd_range", bad, 0);
        check_eq("len8_writes", wr_n, 8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("len8_wr%0d", i), wr_log[i], (i < 4) ? 2 * i + 1 : 2 * (i - 4));
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("len8_fwd_mem%0d", i), mem[i], row8_fwd[i]);
        check_eq("len8_mem8_untouched", mem[8], 999);
        run_row(6'd0, 7'd8, 1'b0, 0, 0, bl, da);
        check_eq("len8_inv_busy", bl, exp_busy(8));
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("len8_inv_mem%0d", i), mem[i], 55 + i);

        // Row wrapping the top of the RAM.
        load(6'd61, 16'd555); load(6'd62, 16'd100); load(6'd63, 16'd110);
        load(6'd0, 16'd120);  load(6'd1, 16'd130);  load(6'd2, 16'd777);
        run_row(6'd62, 7'd4, 1'b1, 0, 0, bl, da);
        check_eq("wrap_busy", bl, exp_busy(4));
        bad = 0;
        for (int i = 0; i < rd_n; i++)
            if (!(rd_log[i] inside {62, 63, 0, 1})) bad++;
        for (int i = 0; i < wr_n; i++)
            if (!(wr_log[i] inside {62, 63, 0, 1})) bad++;
        check_eq("wrap_addr_range", bad, 0);
        check_eq("wrap_mem62", mem[62], 100);
        check_eq("wrap_mem63", mem[63], 0);
        check_eq("wrap_mem0", mem[0], 123);
        check_eq("wrap_mem1", mem[1], 10);
        check_eq("wrap_mem61", mem[61], 555);
        check_eq("wrap_mem2", mem[2], 777);

        // Rejected lengths.
        err_case(7'd5);
        err_case(7'd0);
        err_case(7'd1);
        err_case(7'd66);

        // Stray start while busy must not disturb the row in flight.
        load(6'd4, 16'd10); load(6'd5, 16'd20);
        run_row(6'd4, 7'd2, 1'b1, 5, 0, bl, da);
        check_eq("poke_busy", bl, 13);
        check_eq("poke_mem4", mem[4], 15);
        check_eq("poke_mem5", mem[5], 10);
        check_eq("poke_writes", wr_n, 2);
        bad = 0;
        for (int i = 0; i < rd_n; i++) if (!(rd_log[i] inside {4, 5})) bad++;
        check_eq("poke_rd_range", bad, 0);
        check_eq("poke_after_busy", busy, 0);

        // Reset during the third target's LIFT cycle, then a clean rerun.
        for (int i = 0; i < 8; i++) load(6'(i), 16'(55 + i));
        run_row(6'd0, 7'd8, 1'b1, 0, WIN ? 15 : 17, bl, da);
        #1;
        check_eq("rst_outs", outs, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_writes", wr_n, 2);
        check_eq("rst_mem5", mem[5], 60);
        check_eq("rst_outs_held", outs, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) load(6'(i), 16'(55 + i));
        run_row(6'd0, 7'd8, 1'b1, 0, 0, bl, da);
        check_eq("rerun_busy", bl, exp_busy(8));
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("rerun_mem%0d", i), mem[i], row8_fwd[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
